reg_share_arbiter: RTL and testbench

//  Round-robin arbiter and load sequencer for one shared W-bit register built from D flip-flops.

---
 rtl/reg_share_arbiter_pkg.sv | 19 +
 rtl/reg_share_arbiter_rr_pick4.sv | 29 ++
 rtl/reg_share_arbiter.sv | 130 +++++++++++++
 tb/tb_reg_share_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the round-robin register-share arbiter: FSM encoding,
// requester count and a one-hot helper.
package reg_share_arbiter_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDXW = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic logic [NREQ-1:0] onehot4(input logic [IDXW-1:0] idx);
    onehot4 = NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick4.sv
// Rotate-priority search over four requesters: first set bit after 'last',
// wrapping around, with 'last' itself considered lowest priority.
module rr_pick4
  import reg_share_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] pick,
  output logic            any
);

  logic [IDXW-1:0] idx_c;
  logic            found_c;

  always_comb begin
    pick    = '0;
    idx_c   = '0;
    found_c = 1'b0;
    any     = |req;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx_c = last + IDXW'(k);
      if (!found_c && req[idx_c]) begin
        pick    = idx_c;
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter and load sequencer for one shared W-bit register: grants a
// requester, loads its data slice once, then holds ownership before rearbitrating.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int unsigned W    = 4,
  parameter int unsigned HOLD = 2
) (
  input  logic               c,
  input  logic               re,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*W-1:0]  din,
  output logic [NREQ-1:0]    gnt,
  output logic [IDXW-1:0]    owner,
  output logic               busy,
  output logic               ack,
  output logic [W-1:0]       q
);

  localparam int unsigned CNTW = (HOLD <= 2) ? 1 : $clog2(HOLD);

  if (HOLD < 1) begin : g_bad_hold
    $error("reg_share_arbiter: HOLD must be at least 1");
  end

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic [W-1:0]    q_q, q_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [IDXW-1:0] pick_c;
  logic            any_c;
  logic [W-1:0]    slice_c;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick_c),
    .any  (any_c)
  );

  assign slice_c = din[32'(owner_q) * W +: W];

  always_ff @(posedge c) begin
    if (re) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      q_q     <= '0;
      last_q  <= IDXW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    q_d     = q_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          gnt_d   = onehot4(pick_c);
          owner_d = pick_c;
          busy_d  = 1'b1;
          last_d  = pick_c;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A withdrawn owner releases without loading; last stays on it.
        if (req[owner_q]) begin
          q_d     = slice_c;
          ack_d   = 1'b1;
          state_d = ST_LOAD;
        end else begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (HOLD == 1) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = CNTW'(HOLD - 32'd2);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign ack   = ack_q;
  assign q     = q_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: directed requests push expected loads,
// a negedge monitor pops and checks them on every ack.
module tb_reg_share_arbiter;

  logic        c = 1'b0;
  logic        re, re1;
  logic [3:0]  req, req1;
  logic [15:0] din, din1;
  logic [3:0]  gnt, gnt1;
  logic [1:0]  owner, owner1;
  logic        busy, busy1, ack, ack1;
  logic [3:0]  q, q1;

  typedef struct {
    logic [1:0] owner;
    logic [3:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   mon_en = 1'b0;

  always #5 c = ~c;

  reg_share_arbiter #(.W(4), .HOLD(2)) dut (
    .c(c), .re(re), .req(req), .din(din),
    .gnt(gnt), .owner(owner), .busy(busy), .ack(ack), .q(q)
  );

  reg_share_arbiter #(.W(4), .HOLD(1)) dut1 (
    .c(c), .re(re1), .req(req1), .din(din1),
    .gnt(gnt1), .owner(owner1), .busy(busy1), .ack(ack1), .q(q1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic push(input logic [1:0] o, input logic [3:0] d);
    exp_t e;
    e.owner = o;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: structural invariants every cycle, expected load on every ack.
  always @(negedge c) begin
    if (mon_en) begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("busy_eq_or_gnt", 32'(busy), 32'(|gnt));
      chk("gnt1_onehot0", 32'($onehot0(gnt1)), 32'd1);
      chk("busy1_eq_or_gnt1", 32'(busy1), 32'(|gnt1));
      if (ack) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_ack: got ack=1 expected none (q=%0h owner=%0d) at %0t",
                   q, owner, $time);
        end else begin
          exp_t e;
          logic [3:0] oh;
          e  = exp_q.pop_front();
          oh = 4'b0001 << e.owner;
          chk("ack_owner", 32'(owner), 32'(e.owner));
          chk("ack_q", 32'(q), 32'(e.data));
          chk("ack_gnt", 32'(gnt), 32'(oh));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    re = 1'b1; re1 = 1'b1;
    req = 4'b1111; req1 = 4'b0000;
    din = 16'h4321; din1 = 16'h0000;

    // 1/3: reset, then continuous request from all four
    tick(); tick();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    mon_en = 1'b1;
    push(2'd0, 4'h1); push(2'd1, 4'h2); push(2'd2, 4'h3);
    push(2'd3, 4'h4); push(2'd0, 4'h1);
    re = 1'b0; re1 = 1'b0;
    tick();
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_owner", 32'(owner), 32'h0);
    chk("first_busy", 32'(busy), 32'h1);
    wait_drain(40);
    req = 4'b0000;
    tick(); tick(); tick();
    chk("idle_gnt", 32'(gnt), 32'h0);

    // 2: single request, exact timing with HOLD=2
    din = 16'h0A00; req = 4'b0100;
    push(2'd2, 4'hA);
    tick();
    chk("t2_e0_gnt", 32'(gnt), 32'h4);
    tick();
    chk("t2_e1_ack", 32'(ack), 32'h1);
    chk("t2_e1_q", 32'(q), 32'hA);
    req = 4'b0000;
    tick();
    chk("t2_e2_ack", 32'(ack), 32'h0);
    chk("t2_e2_gnt", 32'(gnt), 32'h4);
    tick();
    chk("t2_e3_gnt", 32'(gnt), 32'h0);
    chk("t2_e3_busy", 32'(busy), 32'h0);

    // 4: withdraw during GRANT, then 0 wins over 1
    din = 16'h0050; req = 4'b0010;
    tick();
    chk("t4_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    chk("t4_wd_gnt", 32'(gnt), 32'h0);
    chk("t4_wd_busy", 32'(busy), 32'h0);
    chk("t4_wd_ack", 32'(ack), 32'h0);
    chk("t4_wd_q", 32'(q), 32'hA);
    din = 16'h0056; req = 4'b0011;
    push(2'd0, 4'h6);
    tick();
    chk("t4_next_gnt", 32'(gnt), 32'h1);
    wait_drain(10);
    req = 4'b0000;
    tick(); tick(); tick();

    // 5: reset pulse during HOLD, last returns to 3
    din = 16'h9000; req = 4'b1000;
    push(2'd3, 4'h9);
    tick();
    chk("t5_gnt", 32'(gnt), 32'h8);
    tick();
    req = 4'b0000;
    tick();
    re = 1'b1;
    tick();
    chk("t5_rst_gnt", 32'(gnt), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_ack", 32'(ack), 32'h0);
    chk("t5_rst_q", 32'(q), 32'h0);
    re = 1'b0; din = 16'h9008; req = 4'b1001;
    push(2'd0, 4'h8);
    tick();
    chk("t5_after_gnt", 32'(gnt), 32'h1);
    wait_drain(10);
    req = 4'b0000;
    tick(); tick(); tick();

    // 6: HOLD=1 instance
    din1 = 16'h0007; req1 = 4'b0001;
    tick();
    chk("t6_e0_gnt", 32'(gnt1), 32'h1);
    tick();
    chk("t6_e1_ack", 32'(ack1), 32'h1);
    chk("t6_e1_q", 32'(q1), 32'h7);
    chk("t6_e1_gnt", 32'(gnt1), 32'h1);
    din1 = 16'h0003;
    tick();
    chk("t6_e2_gnt", 32'(gnt1), 32'h0);
    chk("t6_e2_busy", 32'(busy1), 32'h0);
    chk("t6_e2_ack", 32'(ack1), 32'h0);
    tick();
    chk("t6_e3_gnt", 32'(gnt1), 32'h1);
    chk("t6_e3_ack", 32'(ack1), 32'h0);
    tick();
    chk("t6_e4_ack", 32'(ack1), 32'h1);
    chk("t6_e4_q", 32'(q1), 32'h3);
    req1 = 4'b0000;
    tick(); tick();

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
